// File: rtl/memory_arbiter_pkg.sv
// Shared request/response types and register state for memory_arbiter.
// Optional ARBITER_ROUND_ROBIN_EN adds the `last` fairness bit to the register struct.
package memory_arbiter_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [1:0]  mem_mode;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_error;
        logic        mem_ready;
    } mem_out_type;

    localparam logic [1:0] idle = 2'd0;
    localparam logic [1:0] inst = 2'd1;
    localparam logic [1:0] data = 2'd2;

    typedef struct packed {
        logic       valid;
        mem_in_type req;
    } pend_type;

    typedef struct packed {
        logic [1:0] owner;
        pend_type   ipend;
        pend_type   dpend;
`ifdef ARBITER_ROUND_ROBIN_EN
        logic       last;    // 0: instruction served last, 1: data served last
`endif
    } arbiter_reg_type;

    function automatic arbiter_reg_type init_arbiter_reg();
        arbiter_reg_type v;
        v       = '0;
        v.owner = idle;
        return v;
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports.
// Define ARBITER_ROUND_ROBIN_EN for alternating priority; default is fixed data priority.
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    input  mem_out_type mem_out,
    output mem_in_type  mem_in
);

    arbiter_reg_type r;
    arbiter_reg_type rin;

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        arbiter_reg_type v;
        mem_in_type      icand;
        mem_in_type      dcand;
        logic            ivalid;
        logic            dvalid;
        logic            can_issue;
        logic            sel_data;

        v        = r;
        mem_in   = '0;
        imem_out = '0;
        dmem_out = '0;

        // A fresh pulse replaces whatever was pending on its port (fetch redirect).
        ivalid = imem_in.mem_valid | r.ipend.valid;
        dvalid = dmem_in.mem_valid | r.dpend.valid;
        icand  = imem_in.mem_valid ? imem_in : r.ipend.req;
        dcand  = dmem_in.mem_valid ? dmem_in : r.dpend.req;

        can_issue = (r.owner == idle) | mem_out.mem_ready;
`ifdef ARBITER_ROUND_ROBIN_EN
        sel_data = dvalid & (~ivalid | ~r.last);
`else
        sel_data = dvalid;
`endif

        v.ipend.valid = ivalid;
        v.ipend.req   = ivalid ? icand : '0;
        v.dpend.valid = dvalid;
        v.dpend.req   = dvalid ? dcand : '0;

        imem_out.mem_rdata = mem_out.mem_rdata;
        imem_out.mem_error = mem_out.mem_error;
        imem_out.mem_ready = mem_out.mem_ready & (r.owner == inst);
        dmem_out.mem_rdata = mem_out.mem_rdata;
        dmem_out.mem_error = mem_out.mem_error;
        dmem_out.mem_ready = mem_out.mem_ready & (r.owner == data);

        if (mem_out.mem_ready) begin
            v.owner = idle;
        end

        if (can_issue & (ivalid | dvalid)) begin
            if (sel_data) begin
                mem_in           = dcand;
                mem_in.mem_instr = 1'b0;
                v.owner          = data;
                v.dpend          = '0;
            end else begin
                mem_in           = icand;
                mem_in.mem_instr = 1'b1;
                v.owner          = inst;
                v.ipend          = '0;
            end
            mem_in.mem_valid = 1'b1;
`ifdef ARBITER_ROUND_ROBIN_EN
            v.last = sel_data;
`endif
        end

        if (reset) begin
            mem_in   = '0;
            imem_out = '0;
            dmem_out = '0;
        end

        rin = v;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r <= init_arbiter_reg();
        end else begin
            r <= rin;
        end
    end

endmodule
